// File: rtl/apu_audio_pkg.sv
// Shared audio definitions for the APU audio path.
// Holds the mixer sample width, I2S slot/frame sizes, the midscale code and
// the conversion from the unsigned mixer sample to a signed 16-bit slot word.
package apu_audio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 9;
  localparam int unsigned SLOT_BITS    = 16;
  localparam int unsigned FRAME_BITS   = 32;
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = 9'd256;

  // Offset-binary to two's complement: flip the MSB, left-justify in 16 bits.
  function automatic logic [SLOT_BITS-1:0] sample_to_slot(input logic [SAMPLE_WIDTH-1:0] s);
    return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0], 7'b0};
  endfunction

endpackage

// File: rtl/i2s_bclk_divider.sv
// I2S bit-clock divider.
// Counts 0..CLKS_PER_HALF_BCLK-1 and toggles the bit clock on terminal count,
// so one BCLK period is 2*CLKS_PER_HALF_BCLK clocks.
// Ports:
//   clk_i      - system clock
//   rst_ni     - asynchronous active-low reset
//   bclk_o     - registered bit clock
//   fall_stb_o - high in the cycle whose rising clk edge drives bclk_o 1->0
module i2s_bclk_divider #(
  parameter int unsigned CLKS_PER_HALF_BCLK = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bclk_o,
  output logic fall_stb_o
);

  localparam logic [7:0] TermCnt = 8'(CLKS_PER_HALF_BCLK - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       bclk_q, bclk_d;
  logic       term;

  always_comb begin
    term       = (cnt_q == TermCnt);
    cnt_d      = term ? 8'd0 : cnt_q + 8'd1;
    bclk_d     = bclk_q ^ term;
    fall_stb_o = term & bclk_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 8'd0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;

endmodule

// File: rtl/audio_i2s_transmitter.sv
// I2S transmitter for the 9-bit mixer output.
// A single holding register accepts one sample per frame via valid/ready; at
// each frame start the converted word is loaded into both slots of a 32-bit
// shift register. With no sample held the frame is an underrun and a fallback
// word is sent instead.
// Configuration macro APU_I2S_HOLD_LAST_EN: when defined the underrun fallback
// is the last transmitted word, otherwise midscale silence (16'h0000).
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_sample, i_sample_valid, o_sample_ready - sample handshake
//   o_bclk, o_lrclk, o_sdata - I2S bus (data lags word select by one BCLK)
//   o_frame_stb, o_underrun  - one-cycle pulses at frame start
//   o_underrun_count         - saturating underrun count
module audio_i2s_transmitter #(
  parameter int unsigned CLKS_PER_HALF_BCLK = 4,
  parameter int unsigned SLOT_BITS          = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_sample,
  input  logic       i_sample_valid,
  output logic       o_sample_ready,
  output logic       o_bclk,
  output logic       o_lrclk,
  output logic       o_sdata,
  output logic       o_frame_stb,
  output logic       o_underrun,
  output logic [7:0] o_underrun_count
);

  import apu_audio_pkg::*;

  logic        fall_stb;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic        frame_stb_q, frame_stb_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  urun_cnt_q, urun_cnt_d;
  logic        flag_q, flag_d;
  logic [8:0]  hold_q, hold_d;
  logic [31:0] shreg_q, shreg_d;
  logic [15:0] hold_word, fallback_word;
  logic        frame_start, accept;

  i2s_bclk_divider #(
    .CLKS_PER_HALF_BCLK(CLKS_PER_HALF_BCLK)
  ) u_div (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .bclk_o    (o_bclk),
    .fall_stb_o(fall_stb)
  );

`ifdef APU_I2S_HOLD_LAST_EN
  logic [15:0] last_q, last_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= 16'h0000;
    else          last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (frame_start && flag_q) last_d = hold_word;
  end

  assign fallback_word = last_q;
`else
  assign fallback_word = sample_to_slot(MIDSCALE);
`endif

  assign hold_word   = sample_to_slot(hold_q);
  assign frame_start = fall_stb && (bit_idx_q == 5'd31);
  assign accept      = i_sample_valid && !flag_q;

  always_comb begin
    bit_idx_d   = bit_idx_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    shreg_d     = shreg_q;
    flag_d      = flag_q;
    hold_d      = hold_q;
    urun_cnt_d  = urun_cnt_q;
    frame_stb_d = frame_start;
    underrun_d  = frame_start && !flag_q;

    if (fall_stb) begin
      bit_idx_d = bit_idx_q + 5'd1;
      lrclk_d   = (32'(bit_idx_d) >= SLOT_BITS);
      // Data lags word select by one bit: index 0 still carries the previous
      // frame's last bit, so the new frame is loaded without shifting.
      sdata_d   = shreg_q[31];
      if (frame_start) begin
        shreg_d = flag_q ? {hold_word, hold_word} : {fallback_word, fallback_word};
      end else begin
        shreg_d = {shreg_q[30:0], 1'b0};
      end
    end

    if (frame_start) begin
      if (flag_q) begin
        flag_d = 1'b0;
      end else if (urun_cnt_q != 8'hFF) begin
        urun_cnt_d = urun_cnt_q + 8'd1;
      end
    end

    // Only possible with flag clear, so never collides with the load above.
    if (accept) begin
      flag_d = 1'b1;
      hold_d = i_sample;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_idx_q   <= 5'd31;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      shreg_q     <= 32'd0;
      flag_q      <= 1'b0;
      hold_q      <= 9'd0;
      urun_cnt_q  <= 8'd0;
      frame_stb_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_idx_q   <= bit_idx_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      shreg_q     <= shreg_d;
      flag_q      <= flag_d;
      hold_q      <= hold_d;
      urun_cnt_q  <= urun_cnt_d;
      frame_stb_q <= frame_stb_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_sample_ready   = ~flag_q;
  assign o_lrclk          = lrclk_q;
  assign o_sdata          = sdata_q;
  assign o_frame_stb      = frame_stb_q;
  assign o_underrun       = underrun_q;
  assign o_underrun_count = urun_cnt_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Directed testbench for audio_i2s_transmitter with CLKS_PER_HALF_BCLK = 2
// (BCLK period 4 clocks, frame 128 clocks). Outputs are sampled on the
// falling clk edge.
module tb_audio_i2s_transmitter;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] i_sample = 9'd0;
  logic       i_sample_valid = 1'b0;
  logic       o_sample_ready, o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun;
  logic [7:0] o_underrun_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef APU_I2S_HOLD_LAST_EN
  localparam logic [15:0] FbAfter511 = 16'h7F80;
`else
  localparam logic [15:0] FbAfter511 = 16'h0000;
`endif

  audio_i2s_transmitter #(
    .CLKS_PER_HALF_BCLK(2)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_sample        (i_sample),
    .i_sample_valid  (i_sample_valid),
    .o_sample_ready  (o_sample_ready),
    .o_bclk          (o_bclk),
    .o_lrclk         (o_lrclk),
    .o_sdata         (o_sdata),
    .o_frame_stb     (o_frame_stb),
    .o_underrun      (o_underrun),
    .o_underrun_count(o_underrun_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] left_of(input logic [31:0] b);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = b[1+k];
    return w;
  endfunction

  // Right slot bits 15..1; its LSB appears at index 0 of the following frame.
  function automatic logic [14:0] right_hi_of(input logic [31:0] b);
    logic [14:0] w;
    for (int k = 0; k < 15; k++) w[14-k] = b[17+k];
    return w;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_sample_valid = 1'b0;
    i_sample = 9'd0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_frame_stb === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_stb_timeout: got %b want 1", seen);
    end
  endtask

  // Entered on a frame_stb cycle; returns on the next frame_stb cycle.
  task automatic capture_frame(output logic [31:0] b);
    for (int n = 0; n < 32; n++) begin
      b[n] = o_sdata;
      n_checks++;
      if (o_lrclk !== (n >= 16)) begin
        n_fail++;
        $display("FAIL lrclk_idx%0d: got %b want %b", n, o_lrclk, (n >= 16));
      end
      n_checks++;
      if (o_bclk !== 1'b0) begin
        n_fail++;
        $display("FAIL bclk_low_idx%0d: got %b want 0", n, o_bclk);
      end
      repeat (2) @(negedge i_clk);
      n_checks++;
      if (o_bclk !== 1'b1) begin
        n_fail++;
        $display("FAIL bclk_high_idx%0d: got %b want 1", n, o_bclk);
      end
      repeat (2) @(negedge i_clk);
    end
    n_checks++;
    if (o_frame_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_period: frame_stb got %b want 1 after 128 clocks", o_frame_stb);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun, o_underrun_count, o_sample_ready}
        !== {5'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got bclk%b lr%b sd%b fs%b ur%b cnt%0d rdy%b want 0,0,0,0,0,0,1",
               o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun, o_underrun_count,
               o_sample_ready);
    end
  endtask

  task automatic test_full_scale();
    logic [31:0] b;
    do_reset();
    i_rst_n = 1'b1;
    i_sample = 9'd511;
    i_sample_valid = 1'b1;
    wait_frame();
    n_checks++;
    if (o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_first_underrun: got %b want 0", o_underrun);
    end
    capture_frame(b);
    n_checks++;
    if (b[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_f1_idx0: got %b want 0", b[0]);
    end
    n_checks++;
    if (left_of(b) !== 16'h7F80) begin
      n_fail++;
      $display("FAIL fs_f1_left: got %h want 7f80", left_of(b));
    end
    n_checks++;
    if (right_hi_of(b) !== 15'h3FC0) begin
      n_fail++;
      $display("FAIL fs_f1_right: got %h want 3fc0", right_hi_of(b));
    end
    capture_frame(b);
    n_checks++;
    if ({b[0], left_of(b), right_hi_of(b)} !== {1'b0, 16'h7F80, 15'h3FC0}) begin
      n_fail++;
      $display("FAIL fs_f2_data: got %b/%h/%h want 0/7f80/3fc0", b[0], left_of(b),
               right_hi_of(b));
    end
    i_sample_valid = 1'b0;
  endtask

  task automatic test_sequence();
    logic [31:0] b;
    do_reset();
    i_rst_n = 1'b1;
    i_sample = 9'd0;
    i_sample_valid = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
    wait_frame();
    n_checks++;
    if (o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_f1_underrun: got %b want 0", o_underrun);
    end
    i_sample = 9'd256;
    i_sample_valid = 1'b1;
    // Once 256 is held, a changed sample with valid high must be ignored.
    fork
      capture_frame(b);
      begin
        repeat (2) @(negedge i_clk);
        i_sample = 9'd511;
      end
    join
    i_sample_valid = 1'b0;
    n_checks++;
    if ({left_of(b), right_hi_of(b)} !== {16'h8000, 15'h4000}) begin
      n_fail++;
      $display("FAIL seq_f1_data: got %h/%h want 8000/4000", left_of(b), right_hi_of(b));
    end
    n_checks++;
    if ({o_underrun, o_underrun_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL seq_f2_underrun: got %b cnt %0d want 0 cnt 0", o_underrun,
               o_underrun_count);
    end
    capture_frame(b);
    n_checks++;
    if ({b[0], left_of(b), right_hi_of(b)} !== {1'b0, 16'h0000, 15'h0000}) begin
      n_fail++;
      $display("FAIL seq_f2_data: got %b/%h/%h want 0/0000/0000", b[0], left_of(b),
               right_hi_of(b));
    end
  endtask

  task automatic test_underrun();
    logic [31:0] b;
    do_reset();
    i_rst_n = 1'b1;
    i_sample = 9'd511;
    i_sample_valid = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
    wait_frame();
    capture_frame(b);
    for (int f = 2; f <= 4; f++) begin
      n_checks++;
      if (o_underrun !== 1'b1) begin
        n_fail++;
        $display("FAIL ur_f%0d_pulse: got %b want 1", f, o_underrun);
      end
      if (f < 4) begin
        capture_frame(b);
        n_checks++;
        if (left_of(b) !== FbAfter511) begin
          n_fail++;
          $display("FAIL ur_f%0d_data: got %h want %h", f, left_of(b), FbAfter511);
        end
      end
    end
    n_checks++;
    if (o_underrun_count !== 8'd3) begin
      n_fail++;
      $display("FAIL ur_count: got %0d want 3", o_underrun_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] b;
    do_reset();
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    // Next rising edge is the first frame start.
    i_sample = 9'd0;
    i_sample_valid = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
    n_checks++;
    if ({o_frame_stb, o_underrun, o_underrun_count, o_sample_ready} !== {2'b11, 8'd1, 1'b0})
    begin
      n_fail++;
      $display("FAIL sc_start: got fs%b ur%b cnt%0d rdy%b want 1,1,1,0", o_frame_stb,
               o_underrun, o_underrun_count, o_sample_ready);
    end
    capture_frame(b);
    n_checks++;
    if (left_of(b) !== 16'h0000) begin
      n_fail++;
      $display("FAIL sc_f1_data: got %h want 0000", left_of(b));
    end
    n_checks++;
    if ({o_underrun, o_underrun_count} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL sc_f2_underrun: got %b cnt %0d want 0 cnt 1", o_underrun,
               o_underrun_count);
    end
    capture_frame(b);
    n_checks++;
    if ({left_of(b), right_hi_of(b)} !== {16'h8000, 15'h4000}) begin
      n_fail++;
      $display("FAIL sc_f2_data: got %h/%h want 8000/4000", left_of(b), right_hi_of(b));
    end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    i_rst_n = 1'b1;
    for (int f = 0; f < 300; f++) wait_frame();
    n_checks++;
    if ({o_underrun, o_underrun_count} !== {1'b1, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_count: got ur%b cnt %0d want 1 cnt 255", o_underrun,
               o_underrun_count);
    end
    repeat (82) @(negedge i_clk);
    n_checks++;
    if ({o_lrclk, o_bclk} !== 2'b11) begin
      n_fail++;
      $display("FAIL sat_midslot: got lr%b bclk%b want 1,1", o_lrclk, o_bclk);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun, o_underrun_count, o_sample_ready}
        !== {5'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got bclk%b lr%b sd%b fs%b ur%b cnt%0d rdy%b want 0,0,0,0,0,0,1",
               o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun, o_underrun_count,
               o_sample_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    n_checks++;
    if ({o_frame_stb, o_underrun, o_underrun_count, o_lrclk} !== {2'b11, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_frame: got fs%b ur%b cnt%0d lr%b want 1,1,1,0", o_frame_stb,
               o_underrun, o_underrun_count, o_lrclk);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_sequence();
    test_underrun();
    test_same_cycle();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_i2s_transmitter.md
AUDIO_I2S_TRANSMITTER -- requirements
Module: audio_i2s_transmitter

Interface
REQ-001 Parameter CLKS_PER_HALF_BCLK, default 4: i_clk cycles per BCLK half-period; legal range 2..255.
REQ-002 Parameter SLOT_BITS, fixed at 16: BCLK periods per channel slot; frame = 32 BCLK.
REQ-003 i_clk  in  1  sole clock; every register in the block is clocked on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_sample  in  9  unsigned mixer sample, 0..511, midscale 256.
REQ-006 i_sample_valid  in  1  i_sample is valid this cycle.
REQ-007 o_sample_ready  out  1  block accepts i_sample this cycle.
REQ-008 o_bclk  out  1  I2S bit clock.
REQ-009 o_lrclk  out  1  I2S word select; 0 = left, 1 = right.
REQ-010 o_sdata  out  1  I2S serial data.
REQ-011 o_frame_stb  out  1  one-cycle pulse at each frame start.
REQ-012 o_underrun  out  1  one-cycle pulse when a frame starts with no sample held.
REQ-013 o_underrun_count  out  8  saturating underrun counter.

Function
REQ-014 Divider: counter 0..CLKS_PER_HALF_BCLK-1; o_bclk toggles on terminal count, giving BCLK period 2*CLKS_PER_HALF_BCLK clocks.
REQ-015 Falling-edge event (o_bclk 1->0) advances a 5-bit bit index 0..31 with wrap; o_sdata and o_lrclk change only on falling-edge events.
REQ-016 o_lrclk = 0 for bit index 0..15 and 1 for 16..31.
REQ-017 o_sdata lags o_lrclk by one BCLK (standard I2S): at bit index n it carries frame bit (n-1) mod 32, MSB first per slot.
REQ-018 Conversion: slot word = {~s[8], s[7:0], 7'b0}. Examples: 256 -> 16'h0000, 0 -> 16'h8000, 511 -> 16'h7F80.
REQ-019 The same slot word is sent in both left and right slots.
REQ-020 Single holding register plus valid flag; o_sample_ready = ~flag; handshake completes on i_sample_valid & o_sample_ready.
REQ-021 Frame start = falling-edge event on which the bit index wraps to 0; o_frame_stb pulses in that cycle.
REQ-022 At frame start, flag set: the 32-bit shift register loads {word, word} and flag clears in the same cycle.
REQ-023 At frame start, flag clear: underrun; o_underrun pulses; o_underrun_count increments and saturates at 255; the shift register loads the fallback word (REQ-029).
REQ-024 Handshake in the same cycle as frame start with flag clear: the sample fills the holding register for the next frame; the current frame is still an underrun.
REQ-025 The holding register is never overwritten while flag is set; valid with ready low is ignored.

Reset
REQ-026 Asynchronous assert: o_bclk=0, o_lrclk=0, o_sdata=0, o_frame_stb=0, o_underrun=0, o_underrun_count=0, flag=0, divider=0, bit index=31, shift register=0, last-word register=0.
REQ-027 First falling edge after reset release is a frame start.
REQ-028 Reset mid-frame aborts the frame immediately; no partial-frame completion.

Configuration
REQ-029 Macro APU_I2S_HOLD_LAST_EN: defined -> underrun fallback is the last successfully transmitted word; undefined -> fallback is 16'h0000 (midscale silence) and no last-word register is built.

Structure
REQ-030 Shared package apu_audio_pkg holds SAMPLE_WIDTH=9, SLOT_BITS=16, FRAME_BITS=32, MIDSCALE=9'd256, and the sample-to-slot conversion function.
REQ-031 One sub-module, i2s_bclk_divider, implements REQ-014 and supplies the falling-edge strobe; everything else is inline.

Verification
REQ-032 CLKS_PER_HALF_BCLK=2, sample 9'd511 held valid -> BCLK period 4 clocks; each slot shifts out 0111_1111_1000_0000 MSB-first, one BCLK after each LRCLK edge.
REQ-033 Samples 0 then 256 fed one per frame -> frame 1 slots 16'h8000, frame 2 slots 16'h0000; o_underrun never pulses.
REQ-034 No valid for 3 frames -> 3 o_underrun pulses, o_underrun_count=3; data is 16'h0000 without the macro, or the previous word with APU_I2S_HOLD_LAST_EN.
REQ-035 Valid asserted in exactly the frame-start cycle with flag clear -> underrun counted; that sample is sent in the next frame.
REQ-036 300 consecutive underruns -> o_underrun_count=255; then i_rst_n pulsed low mid-slot -> all outputs take reset values asynchronously.
